// File: rtl/taillight_input_conditioner.sv
// taillight_input_conditioner: synchronise/debounce five driver switches; produce step, dim and change strobes
//   clk, rst (sync, active-high)
//   in : left_sw, right_sw, brake_sw, hazard_sw, runlight_sw (raw, asynchronous)
//   out: left, right, brake, hazard, runlight (debounced), step_tick, dim_tick, changed (one-cycle strobes)
module taillight_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STEP_DIV = 8,
  parameter int DIM_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic left_sw,
  input  logic right_sw,
  input  logic brake_sw,
  input  logic hazard_sw,
  input  logic runlight_sw,
  output logic left,
  output logic right,
  output logic brake,
  output logic hazard,
  output logic runlight,
  output logic step_tick,
  output logic dim_tick,
  output logic changed
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(STEP_DIV);
  localparam int DW = $clog2(DIM_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SCNT_LAST = SW'(STEP_DIV - 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DIM_DIV - 1);
  logic [4:0] s1_q, s1_d, s2_q, s2_d, out_q, out_d, flip;
  logic [CW-1:0] cnt_q [5];
  logic [CW-1:0] cnt_d [5];
  logic [SW-1:0] scnt_q, scnt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic step_q, step_d, dim_q, dim_d, chg_q, chg_d, turn_evt;
  // bit order: 0 left, 1 right, 2 brake, 3 hazard, 4 runlight
  always_comb begin
    s1_d = {runlight_sw, hazard_sw, brake_sw, right_sw, left_sw};
    s2_d = s1_q;
    for (int i = 0; i < 5; i++) begin
      flip[i] = s2_q[i] != out_q[i] && cnt_q[i] == CNT_LAST;
      cnt_d[i] = s2_q[i] == out_q[i] || flip[i] ? '0 : cnt_q[i] + 1'b1;
    end
    out_d = out_q ^ flip;
    chg_d = |flip;
    turn_evt = flip[0] | flip[1] | flip[3];
    step_d = turn_evt || scnt_q == SCNT_LAST;
    scnt_d = step_d ? '0 : scnt_q + 1'b1;
    dim_d = dcnt_q == DCNT_LAST;
    dcnt_d = dim_d ? '0 : dcnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      out_q <= '0;
      cnt_q <= '{default: '0};
      scnt_q <= '0;
      dcnt_q <= '0;
      step_q <= 1'b0;
      dim_q <= 1'b0;
      chg_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      out_q <= out_d;
      cnt_q <= cnt_d;
      scnt_q <= scnt_d;
      dcnt_q <= dcnt_d;
      step_q <= step_d;
      dim_q <= dim_d;
      chg_q <= chg_d;
    end
  end
  assign {runlight, hazard, brake, right, left} = out_q;
  assign step_tick = step_q;
  assign dim_tick = dim_q;
  assign changed = chg_q;
endmodule

// File: tb/tb_taillight_input_conditioner.sv
// tb_taillight_input_conditioner: directed and random stimulus checked against a history-based reference model
module tb_taillight_input_conditioner;
  localparam int D = 4;
  localparam int SD = 8;
  localparam int DD = 4;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] raw;
  logic left, right, brake, hazard, runlight, step_tick, dim_tick, changed;
  int n_assert = 0;
  int n_fail = 0;
  // model: n = edges since reset, rq[k] = raw sampled at edge k+1
  int n;
  logic [4:0] rq [$];
  logic [4:0] m_out;
  int last_flip [5];
  int last_turn;
  logic m_step, m_dim, m_chg;
  logic [4:0] cur;
  always #5 clk = ~clk;
  taillight_input_conditioner #(.DEBOUNCE_CYCLES(D), .STEP_DIV(SD), .DIM_DIV(DD)) dut (
    .clk(clk), .rst(rst),
    .left_sw(raw[0]), .right_sw(raw[1]), .brake_sw(raw[2]), .hazard_sw(raw[3]), .runlight_sw(raw[4]),
    .left(left), .right(right), .brake(brake), .hazard(hazard), .runlight(runlight),
    .step_tick(step_tick), .dim_tick(dim_tick), .changed(changed)
  );
  // level seen by the debouncer at edge j: raw sampled two edges earlier (0 straight after reset)
  function automatic logic vb(input int j, input int i);
    return j >= 3 ? rq[j-3][i] : 1'b0;
  endfunction
  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b at edge %0d", tag, obs, exp, n);
    end
  endtask
  task automatic tick(input logic [4:0] r, input logic rs);
    logic [4:0] flips;
    logic ok, turn;
    raw = r;
    rst = rs;
    @(posedge clk);
    if (rs) begin
      n = 0;
      rq.delete();
      m_out = '0;
      for (int i = 0; i < 5; i++) last_flip[i] = 0;
      last_turn = 0;
      m_step = 1'b0;
      m_dim = 1'b0;
      m_chg = 1'b0;
    end else begin
      n++;
      rq.push_back(r);
      flips = '0;
      // an output follows once the last D edges since its previous change all disagree with it
      for (int i = 0; i < 5; i++) begin
        ok = 1'b1;
        for (int j = n - D + 1; j <= n; j++)
          if (j < 1 || j <= last_flip[i] || vb(j, i) == m_out[i]) ok = 1'b0;
        flips[i] = ok;
        if (ok) last_flip[i] = n;
      end
      m_out = m_out ^ flips;
      m_chg = |flips;
      turn = flips[0] | flips[1] | flips[3];
      if (turn) last_turn = n;
      m_step = turn || ((n - last_turn) % SD == 0);
      m_dim = (n % DD) == 0;
    end
    @(negedge clk);
    check("debounced", {runlight, hazard, brake, right, left}, m_out);
    check("step_tick", {4'b0, step_tick}, {4'b0, m_step});
    check("dim_tick", {4'b0, dim_tick}, {4'b0, m_dim});
    check("changed", {4'b0, changed}, {4'b0, m_chg});
  endtask
  task automatic hold(input logic [4:0] r, input int cycles);
    for (int k = 0; k < cycles; k++) tick(r, 1'b0);
  endtask
  initial begin
    n = 0;
    m_out = '0;
    last_turn = 0;
    for (int i = 0; i < 5; i++) last_flip[i] = 0;
    for (int k = 0; k < 3; k++) tick(5'b00000, 1'b1);
    hold(5'b00000, 16);
    hold(5'b00001, 16);
    hold(5'b00101, 3);
    hold(5'b00001, 8);
    hold(5'b00101, 4);
    hold(5'b00001, 10);
    tick(5'b01001, 1'b0);
    tick(5'b00001, 1'b0);
    hold(5'b01001, 4);
    hold(5'b01001, 12);
    hold(5'b00000, 10);
    hold(5'b00001, 3);
    tick(5'b00001, 1'b1);
    hold(5'b00001, 12);
    hold(5'b00000, 10);
    hold(5'b00011, 12);
    cur = 5'b00011;
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 5; i++)
        if ($urandom_range(0, 4) == 0) cur[i] = ~cur[i];
      tick(cur, k == 150 || k == 151);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
